traffic_arbiter: RTL and testbench
==================================

TRAFFIC_ARBITER -- requirements
Module: traffic_arbiter

Interface
REQ-001 Parameter GREEN_MIN, default 4: minimum green duration, in clk cycles (must be 1 or more).
REQ-002 Parameter GREEN_MAX, default 10: maximum green duration while the other road waits (must be GREEN_MIN or more).
REQ-003 Parameter YELLOW_TIME, default 2: yellow duration, in clk cycles.
REQ-004 Parameter ALLRED_TIME, default 1: all-red clearance duration, in clk cycles.
REQ-005 Parameter WALK_TIME, default 3: pedestrian walk duration, in clk cycles; used only under PED_EN.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset; block is in reset while rst=0.
REQ-008 priority  in  1  from priority_gen; 0 favours road A, 1 favours road B.
REQ-009 car_a  in  1  vehicle waiting on road A, level-sensitive.
REQ-010 car_b  in  1  vehicle waiting on road B, level-sensitive.
REQ-011 ped_req  in  1  pedestrian button pulse; present only under PED_EN.
REQ-012 light_a  out  3  one-hot {red,yellow,green} for road A.
REQ-013 light_b  out  3  one-hot {red,yellow,green} for road B.
REQ-014 ped_walk  out  1  walk lamp; present only under PED_EN.

Function
REQ-015 States: A_GREEN, A_YELLOW, ALLRED_AB, B_GREEN, B_YELLOW, ALLRED_BA, plus WALK under PED_EN.
REQ-016 Timer: width $clog2(max of all durations)+1; cleared on every state change; otherwise increments by 1 each cycle.
REQ-017 Timer saturation: in green states the timer saturates at GREEN_MAX-1 and never wraps.
REQ-018 Output decode: light_a and light_b decode from the state register only (Moore).
REQ-019 Output timing: outputs change in the same cycle as the state; there is no combinational path from any input to any output.
REQ-020 Light mapping:
- A_GREEN: A=green, B=red.
- A_YELLOW: A=yellow, B=red.
- B_GREEN: A=red, B=green.
- B_YELLOW: A=red, B=yellow.
- ALLRED_AB, ALLRED_BA, WALK: both red.
REQ-021 A_GREEN leaves for A_YELLOW when either holds:
- timer>=GREEN_MIN-1, car_b=1, and (car_a=0 or priority=1);
- timer==GREEN_MAX-1 and car_b=1.
REQ-022 A_GREEN with car_b=0 holds indefinitely, with A green.
REQ-023 B_GREEN mirrors REQ-021/022 with roads swapped; it is favoured when priority=0.
REQ-024 Yellow: a yellow state lasts exactly YELLOW_TIME cycles, then goes to its ALLRED state.
REQ-025 All-red: an ALLRED state lasts exactly ALLRED_TIME cycles.
REQ-026 All-red exit: after ALLRED_AB goes to B_GREEN; after ALLRED_BA goes to A_GREEN (except REQ-031).
REQ-027 Decision latency: inputs are sampled at the edge; a satisfied condition changes state at that same edge.
REQ-028 Conflicting greens: both lights green in the same cycle never occurs, including during and immediately after reset.
REQ-029 A priority toggle during a yellow or all-red state has no effect on that state.

Reset
REQ-030 While rst=0 the block holds:
- state=A_GREEN, timer=0;
- light_a=001 (green), light_b=100 (red);
- ped_walk=0 and ped latch=0;
- this applies immediately, including mid-yellow or mid-walk.

Configuration
REQ-031 Macro PED_EN defined:
- ped_req is latched into ped_pend;
- ALLRED_AB and ALLRED_BA go to WALK instead of green when ped_pend=1;
- WALK clears ped_pend on entry, drives ped_walk=1, lasts WALK_TIME cycles;
- WALK then goes to the green that was next;
- a ped_req arriving during WALK is latched for the next cycle.
REQ-032 Macro PED_EN undefined: no ped_req or ped_walk ports, no WALK state, and behaviour per REQ-015..029 only.

Verification
(All scenarios use default parameters.)
REQ-033 car_b=1, car_a=0 from reset release:
- A green for 4 cycles;
- yellow for 2, all-red for 1;
- B green from cycle 8.
REQ-034 car_a=car_b=1, priority=0 constant: A green for 10 cycles (forced at GREEN_MAX), then yellow for 2, all-red for 1, then B green.
REQ-035 Same inputs with priority=1: switch at cycle 4, as in REQ-033.
REQ-036 car_b=0 for 50 cycles: A stays green throughout and the timer holds at 9.
REQ-037 rst=0 asserted during A_YELLOW: outputs at 001/100 asynchronously; after release, A green with timer restarting at 0.
REQ-038 PED_EN, ped_req pulse during A_GREEN with car_b=1: after ALLRED_AB, ped_walk=1 for 3 cycles with both red, then B green.

Source files
------------

// File: rtl/traffic_arbiter.sv
// Two-road traffic light arbiter with min/max green, yellow and all-red phases.
// Optional pedestrian walk phase when PED_EN is defined; prio is the road-preference input from priority_gen.
module traffic_arbiter #(
  parameter int GREEN_MIN   = 4,
  parameter int GREEN_MAX   = 10,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int WALK_TIME   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       prio,
  input  logic       car_a,
  input  logic       car_b,
`ifdef PED_EN
  input  logic       ped_req,
  output logic       ped_walk,
`endif
  output logic [2:0] light_a,
  output logic [2:0] light_b
);

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXD = max2(max2(max2(GREEN_MIN, GREEN_MAX), max2(YELLOW_TIME, ALLRED_TIME)), WALK_TIME);
  localparam int TW   = $clog2(MAXD) + 1;

  localparam logic [TW-1:0] T_GMIN = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] T_GMAX = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] T_Y    = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] T_AR   = TW'(ALLRED_TIME - 1);

  localparam logic [2:0] L_RED = 3'b100, L_YEL = 3'b010, L_GRN = 3'b001;

  typedef enum logic [2:0] {
    A_GREEN, A_YELLOW, ALLRED_AB, B_GREEN, B_YELLOW, ALLRED_BA
`ifdef PED_EN
    , WALK
`endif
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] timer;
  logic          in_green;

  assign in_green = (state == A_GREEN) || (state == B_GREEN);

`ifdef PED_EN
  localparam logic [TW-1:0] T_W = TW'(WALK_TIME - 1);
  logic ped_pend, walk_to_b;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      A_GREEN:
        if (car_b && ((timer >= T_GMIN && (!car_a || prio)) || timer == T_GMAX))
          state_nx = A_YELLOW;
      A_YELLOW:
        if (timer == T_Y) state_nx = ALLRED_AB;
      ALLRED_AB:
        if (timer == T_AR) begin
`ifdef PED_EN
          state_nx = ped_pend ? WALK : B_GREEN;
`else
          state_nx = B_GREEN;
`endif
        end
      B_GREEN:
        if (car_a && ((timer >= T_GMIN && (!car_b || !prio)) || timer == T_GMAX))
          state_nx = B_YELLOW;
      B_YELLOW:
        if (timer == T_Y) state_nx = ALLRED_BA;
      ALLRED_BA:
        if (timer == T_AR) begin
`ifdef PED_EN
          state_nx = ped_pend ? WALK : A_GREEN;
`else
          state_nx = A_GREEN;
`endif
        end
`ifdef PED_EN
      WALK:
        if (timer == T_W) state_nx = walk_to_b ? B_GREEN : A_GREEN;
`endif
      default: state_nx = A_GREEN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= A_GREEN;
      timer <= '0;
    end else begin
      state <= state_nx;
      // Greens saturate so an unopposed road can hold forever without wrap.
      if (state_nx != state)                timer <= '0;
      else if (in_green && timer == T_GMAX) timer <= timer;
      else                                  timer <= timer + 1'b1;
    end
  end

`ifdef PED_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ped_pend  <= 1'b0;
      walk_to_b <= 1'b0;
    end else begin
      if (ped_req)                                ped_pend <= 1'b1;
      else if (state_nx == WALK && state != WALK) ped_pend <= 1'b0;
      // Remember which green the walk phase displaced.
      if (state_nx == WALK && state != WALK)      walk_to_b <= (state == ALLRED_AB);
    end
  end

  assign ped_walk = (state == WALK);
`endif

  always_comb begin
    light_a = L_RED;
    light_b = L_RED;
    case (state)
      A_GREEN:  light_a = L_GRN;
      A_YELLOW: light_a = L_YEL;
      B_GREEN:  light_b = L_GRN;
      B_YELLOW: light_b = L_YEL;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_arbiter.sv
// Scoreboard bench for traffic_arbiter: stimulus queues expected lights per cycle,
// a negedge monitor pops and compares. Pedestrian scenario only when PED_EN is defined.
module tb_traffic_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       prio = 1'b0, car_a = 1'b0, car_b = 1'b0;
  logic [2:0] light_a, light_b;
  logic       pw;
`ifdef PED_EN
  logic       ped_req = 1'b0;
  logic       ped_walk;
  assign pw = ped_walk;
`else
  assign pw = 1'b0;
`endif

  localparam logic [2:0] G = 3'b001, Y = 3'b010, R = 3'b100;

  int vectors = 0;
  int miscompares = 0;
  logic [6:0] q[$];

  always #5 clk = ~clk;

  traffic_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .prio    (prio),
    .car_a   (car_a),
    .car_b   (car_b),
`ifdef PED_EN
    .ped_req (ped_req),
    .ped_walk(ped_walk),
`endif
    .light_a (light_a),
    .light_b (light_b)
  );

  always @(negedge clk) begin
    if (q.size() > 0) begin
      logic [6:0] e;
      e = q.pop_front();
      vectors++;
      if ({light_a, light_b, pw} !== e) begin
        miscompares++;
        $display("FAIL lights @%0t: got a=%b b=%b walk=%b, want a=%b b=%b walk=%b",
                 $time, light_a, light_b, pw, e[6:4], e[3:1], e[0]);
      end
    end
  end

  // Expect the given lights for n consecutive cycles, starting with the current one.
  task automatic chk(input int n, input logic [2:0] la, input logic [2:0] lb, input logic w = 1'b0);
    repeat (n) begin
      q.push_back({la, lb, w});
      @(posedge clk); #1;
    end
  endtask

  task automatic direct(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic ca, input logic cb, input logic pr);
    rst = 1'b0; car_a = ca; car_b = cb; prio = pr;
    chk(2, G, R);
    rst = 1'b1;
  endtask

  initial begin
    @(posedge clk); #1;

    // Only road B waiting: minimum green then switch.
    do_reset(1'b0, 1'b1, 1'b0);
    chk(4, G, R); chk(2, Y, R); chk(1, R, R); chk(3, R, G);

    // Both waiting, A favoured: A forced out at max, B yields at min.
    do_reset(1'b1, 1'b1, 1'b0);
    chk(10, G, R); chk(2, Y, R); chk(1, R, R);
    chk(4, R, G);  chk(2, R, Y); chk(1, R, R); chk(2, G, R);

    // Both waiting, B favoured.
    do_reset(1'b1, 1'b1, 1'b1);
    chk(4, G, R); chk(2, Y, R); chk(1, R, R);
    chk(10, R, G); chk(2, R, Y); chk(1, R, R); chk(1, G, R);

    // No B traffic: A holds, timer saturates; then B arrives at saturation.
    do_reset(1'b1, 1'b0, 1'b0);
    chk(50, G, R);
    direct("timer_sat", int'(dut.timer), 9);
    car_b = 1'b1;
    chk(1, G, R); chk(2, Y, R); chk(1, R, R); chk(1, R, G);

    // Reset asserted mid-yellow acts immediately.
    do_reset(1'b0, 1'b1, 1'b0);
    chk(4, G, R); chk(1, Y, R);
    direct("yellow_before_rst", int'(light_a), int'(Y));
    #2 rst = 1'b0;
    #1;
    direct("async_rst_a", int'(light_a), int'(G));
    direct("async_rst_b", int'(light_b), int'(R));
    @(posedge clk); #1;
    rst = 1'b1;
    direct("timer_restart", int'(dut.timer), 0);
    chk(4, G, R); chk(1, Y, R);

`ifdef PED_EN
    // Pedestrian press during A green inserts a walk before B green.
    do_reset(1'b0, 1'b1, 1'b0);
    ped_req = 1'b1;
    chk(1, G, R);
    ped_req = 1'b0;
    chk(3, G, R); chk(2, Y, R); chk(1, R, R);
    chk(3, R, R, 1'b1); chk(2, R, G);
`endif

    @(posedge clk); @(posedge clk); #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
